ac3_ctrl: RTL and testbench

- Sequencer for the AC3 final accumulation stage. It accepts a programmed number of partial sums from AC2 over a valid/ready handshake and accumulates them through one instance of ac3_adder.
- It then quantizes the total with a serial right shift, one bit per cycle, and saturates it to Pa bits.
- The result is presented on a valid/ready output. The block sits between AC2 and the output/requantization path of the datapath.

---
 rtl/ac3_pkg.sv | 17 +
 rtl/ac3_adder.sv | 10 +
 rtl/ac3_ctrl.sv | 89 ++++++++
 tb/tb_ac3_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ac3_pkg.sv
// ac3_pkg: shared FSM state type, width helpers and saturation for the AC3 stage.
package ac3_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SHIFT, OUT} state_t;
  function automatic int acc_width(input int m, input int pa, input int pw, input int mno);
    return $clog2(m) + pa + pw + $clog2(mno);
  endfunction
  function automatic int cnt_width(input int mno);
    return $clog2(mno) + 1;
  endfunction
  function automatic int sh_width(input int acc_w);
    return $clog2(acc_w) + 1;
  endfunction
  // Clamp v to the largest w-bit unsigned value.
  function automatic logic [63:0] sat(input logic [63:0] v, input int w);
    return ((v >> w) != 64'd0) ? ((64'd1 << w) - 64'd1) : v;
  endfunction
endpackage

// File: rtl/ac3_adder.sv
// ac3_adder: unsigned accumulation adder combining an AC2 partial sum with the running total.
module ac3_adder #(
  parameter int W = 25
) (
  input  logic [W-1:0] in_from_ac2,
  input  logic [W-1:0] in_from_reg,
  output logic [W-1:0] sum
);
  assign sum = in_from_ac2 + in_from_reg;
endmodule

// File: rtl/ac3_ctrl.sv
// ac3_ctrl: accumulates a programmed number of AC2 partial sums, then serially
// right-shifts and saturates the total to Pa bits for a valid/ready output.
module ac3_ctrl
  import ac3_pkg::*;
#(
  parameter int M = 16,
  parameter int Pa = 8,
  parameter int Pw = 4,
  parameter int MNO = 288,
  localparam int ACC_W = acc_width(M, Pa, Pw, MNO),
  localparam int CNT_W = cnt_width(MNO),
  localparam int SH_W = sh_width(ACC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [SH_W-1:0]  shift_amt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Pa-1:0]    out_data,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [ACC_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt;
  logic [SH_W-1:0] shcnt;
  logic [Pa-1:0] sat_v;
  logic beat;
  assign beat = in_valid & in_ready;
  assign sat_v = Pa'(sat(64'(acc), Pa));
  ac3_adder #(.W(ACC_W)) u_add (
    .in_from_ac2(in_data),
    .in_from_reg(acc),
    .sum(sum)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      shcnt <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          cnt <= (num_ops > CNT_W'(MNO)) ? CNT_W'(MNO) : num_ops;
          shcnt <= (shift_amt > SH_W'(ACC_W)) ? SH_W'(ACC_W) : shift_amt;
          busy <= 1'b1;
          in_ready <= (num_ops != '0);
          state <= (num_ops != '0) ? ACCUM : SHIFT;
        end
        ACCUM: if (beat) begin
          acc <= sum;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            in_ready <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: if (shcnt == '0) begin
          out_valid <= 1'b1;
          out_data <= sat_v;
          state <= OUT;
        end else begin
          acc <= acc >> 1;
          shcnt <= shcnt - SH_W'(1);
        end
        OUT: if (out_ready) begin
          done <= 1'b1;
          out_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ac3_ctrl.sv
// tb_ac3_ctrl: table-driven scoreboard bench for the AC3 accumulation sequencer.
module tb_ac3_ctrl;
  typedef struct {
    int n;
    int sh;
    int d[8];
    int stall;
    int hold;
    int poke;
    int lat;
    int exp;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [9:0] num_ops = '0;
  logic [5:0] shift_amt = '0;
  logic [24:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [7:0] out_data;
  int passed = 0, total = 0;
  int sbq[$];
  vec_t tv[8];
  always #5 clk = ~clk;
  ac3_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .shift_amt(shift_amt),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic do_run(input vec_t v, input string tag);
    int lat, i, exp;
    logic [7:0] held;
    bit bt;
    sbq.push_back(v.exp);
    num_ops = 10'(v.n);
    shift_amt = 6'(v.sh);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    i = 0;
    check({tag, " busy"}, int'(busy), 1);
    while (!out_valid && lat < 200) begin
      if (v.poke != 0 && lat == 1) begin
        start = 1;
        num_ops = 10'd5;
      end else start = 0;
      in_valid = (i < v.n) && (i < 8) && (v.stall == 0 || $urandom_range(0, 1) == 1);
      in_data = in_valid ? 25'(v.d[i]) : '0;
      bt = in_valid && in_ready;
      @(posedge clk); #1;
      lat++;
      if (bt) i++;
    end
    start = 0;
    in_valid = 0;
    check({tag, " out_valid"}, int'(out_valid), 1);
    if (v.stall == 0) check({tag, " latency"}, lat, v.lat);
    check({tag, " beats"}, i, v.n);
    repeat (v.hold) begin
      @(posedge clk); #1;
      check({tag, " held data"}, int'(out_data), v.exp);
      check({tag, " held valid"}, int'(out_valid), 1);
      check({tag, " no early done"}, int'(done), 0);
    end
    held = out_data;
    out_ready = 1;
    start = 1;
    num_ops = 10'd1;
    @(posedge clk); #1;
    out_ready = 0;
    start = 0;
    exp = (sbq.size() != 0) ? sbq.pop_front() : -1;
    check({tag, " out_data"}, int'(held), exp);
    check({tag, " done"}, int'(done), 1);
    check({tag, " valid drop"}, int'(out_valid), 0);
    check({tag, " start ignored"}, int'(busy), 0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, int'(done), 0);
    check({tag, " idle"}, int'(busy), 0);
  endtask
  initial begin
    tv[0] = '{4, 2, '{10, 20, 30, 40, 0, 0, 0, 0}, 0, 0, 0, 8, 25};
    tv[1] = '{2, 1, '{300, 300, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 5, 255};
    tv[2] = '{3, 0, '{1, 2, 3, 0, 0, 0, 0, 0}, 0, 0, 0, 5, 6};
    tv[3] = '{5, 0, '{7, 7, 7, 7, 7, 0, 0, 0}, 1, 10, 0, 0, 35};
    tv[4] = '{0, 3, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 1, 5, 0};
    tv[5] = '{8, 4, '{100, 200, 300, 400, 500, 600, 700, 800}, 0, 2, 0, 14, 225};
    tv[6] = '{1, 24, '{33554431, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 27, 1};
    tv[7] = '{1, 30, '{33554431, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 28, 0};
    #12;
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) do_run(tv[k], $sformatf("vec%0d", k));
    num_ops = 10'd4;
    shift_amt = 6'd0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    in_data = 25'd50;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 0;
    check("mid busy", int'(busy), 1);
    check("mid in_ready", int'(in_ready), 1);
    #2;
    rst_n = 0;
    #1;
    check("abort in_ready", int'(in_ready), 0);
    check("abort busy", int'(busy), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_data", int'(out_data), 0);
    check("abort done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("post reset idle", int'(busy), 0);
    do_run('{1, 0, '{9, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 3, 9}, "fresh");
    check("scoreboard empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
